// File: rtl/simon_engine_if.sv
// Handshake bundle between the debounced keypad side and the Simon engine / display side.
// Latency: none (wires only).
// Backpressure: none; start and player_valid are single-cycle strobes.
// Ports (signals):
//   start, player_valid, player_key  -> requests from the keypad/controller (master drives)
//   show_on, show_key, player_turn,
//   level, game_over, win            -> status/display outputs (slave drives)
interface simon_engine_if #(
  parameter int NUM_KEYS  = 4,
  parameter int MAX_LEVEL = 16
);
  localparam int KEY_W = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1;
  localparam int LVL_W = $clog2(MAX_LEVEL + 1);

  logic             start;
  logic             player_valid;
  logic [KEY_W-1:0] player_key;
  logic             show_on;
  logic [KEY_W-1:0] show_key;
  logic             player_turn;
  logic [LVL_W-1:0] level;
  logic             game_over;
  logic             win;

  modport master (
    output start, player_valid, player_key,
    input  show_on, show_key, player_turn, level, game_over, win
  );

  modport slave (
    input  start, player_valid, player_key,
    output show_on, show_key, player_turn, level, game_over, win
  );
endinterface

// File: rtl/simon_engine.sv
// Memory-sequence game engine: grows an LFSR-generated key sequence, replays it, checks presses.
// Latency: every output is registered and reacts one clock after the triggering edge.
// Backpressure: none; start/presses outside their accepting states are dropped.
// Ports: clk (game tick), reset (async, active-high), bus (simon_engine_if.slave).
// Optional build macro SIMON_SPEEDUP_EN: shortens the display time as the level rises.
module simon_engine #(
  parameter int          NUM_KEYS      = 4,
  parameter int          MAX_LEVEL     = 16,
  parameter int          SHOW_TICKS    = 30,
  parameter int          GAP_TICKS     = 30,
  parameter int          TIMEOUT_TICKS = 120,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic            clk,
  input logic            reset,
  simon_engine_if.slave  bus
);

  localparam int KEY_W = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1;
  localparam int LVL_W = $clog2(MAX_LEVEL + 1);
  localparam int IDX_W = (MAX_LEVEL > 2) ? $clog2(MAX_LEVEL) : 1;
  localparam int MAX_T = (SHOW_TICKS > GAP_TICKS)
                         ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                         : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
  localparam int TMR_W = $clog2(MAX_T + 1);

  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_TICKS - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(TIMEOUT_TICKS - 1);
  localparam logic [KEY_W:0]   NK_W      = (KEY_W + 1)'(NUM_KEYS);
  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSE, S_SHOW_ON, S_SHOW_OFF, S_WAIT_KEY, S_WIN, S_LOSE
  } state_t;

  state_t           state_q;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [IDX_W-1:0] idx_q;
  logic [TMR_W-1:0] timer_q;
  logic             show_on_q, player_turn_q, game_over_q, win_q;
  logic [KEY_W-1:0] show_key_q;
  logic [LVL_W-1:0] level_q;

  // Sequence storage is deliberately not reset; entries are always written before being read.
  logic [KEY_W-1:0] mem_q [MAX_LEVEL];

  logic [KEY_W:0]   key_raw;
  logic [KEY_W-1:0] new_key;
  logic             last_idx, key_match, start_game, level_up, mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [TMR_W-1:0] show_last;

  always_comb begin
    // Galois step for x^16+x^14+x^13+x^11+1 (right-shifting form).
    lfsr_d     = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    // Raw value is below 2*NUM_KEYS, so one conditional subtract folds it into range.
    key_raw    = {1'b0, lfsr_q[KEY_W-1:0]};
    new_key    = (key_raw >= NK_W) ? KEY_W'(key_raw - NK_W) : KEY_W'(key_raw);
    last_idx   = (LVL_W'(idx_q) == (level_q - LVL_W'(1)));
    // Stored keys are always < NUM_KEYS, so out-of-range presses can never match.
    key_match  = (bus.player_key == mem_q[idx_q]);
    start_game = bus.start && ((state_q == S_IDLE) || (state_q == S_WIN) || (state_q == S_LOSE));
    level_up   = (state_q == S_WAIT_KEY) && bus.player_valid && key_match && last_idx
                 && (level_q != LVL_MAX);
    mem_we     = start_game || level_up;
    mem_waddr  = start_game ? '0 : IDX_W'(level_q);
  end

`ifdef SIMON_SPEEDUP_EN
  int show_len;
  always_comb begin
    show_len = SHOW_TICKS - 2 * (int'(level_q) - 1);
    if (show_len < SHOW_TICKS / 4) show_len = SHOW_TICKS / 4;
    // Never shorter than one cycle, even for tiny SHOW_TICKS.
    if (show_len < 1) show_len = 1;
    show_last = TMR_W'(show_len - 1);
  end
`else
  assign show_last = TMR_W'(SHOW_TICKS - 1);
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= new_key;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      idx_q         <= '0;
      timer_q       <= '0;
      show_on_q     <= 1'b0;
      show_key_q    <= '0;
      player_turn_q <= 1'b0;
      level_q       <= '0;
      game_over_q   <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (bus.start) begin
            level_q     <= LVL_W'(1);
            idx_q       <= '0;
            timer_q     <= '0;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            state_q     <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (timer_q == GAP_LAST) begin
            timer_q    <= '0;
            idx_q      <= '0;
            show_on_q  <= 1'b1;
            show_key_q <= mem_q[0];
            state_q    <= S_SHOW_ON;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_SHOW_ON: begin
          if (timer_q == show_last) begin
            timer_q    <= '0;
            show_on_q  <= 1'b0;
            show_key_q <= '0;
            state_q    <= S_SHOW_OFF;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_SHOW_OFF: begin
          if (timer_q == GAP_LAST) begin
            timer_q <= '0;
            if (last_idx) begin
              idx_q         <= '0;
              player_turn_q <= 1'b1;
              state_q       <= S_WAIT_KEY;
            end else begin
              idx_q      <= idx_q + IDX_W'(1);
              show_on_q  <= 1'b1;
              show_key_q <= mem_q[idx_q + IDX_W'(1)];
              state_q    <= S_SHOW_ON;
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_WAIT_KEY: begin
          // A press is evaluated ahead of the timeout in the same cycle.
          if (bus.player_valid) begin
            if (!key_match) begin
              player_turn_q <= 1'b0;
              game_over_q   <= 1'b1;
              state_q       <= S_LOSE;
            end else if (!last_idx) begin
              idx_q   <= idx_q + IDX_W'(1);
              timer_q <= '0;
            end else if (level_q == LVL_MAX) begin
              player_turn_q <= 1'b0;
              game_over_q   <= 1'b1;
              win_q         <= 1'b1;
              state_q       <= S_WIN;
            end else begin
              level_q       <= level_q + LVL_W'(1);
              idx_q         <= '0;
              timer_q       <= '0;
              player_turn_q <= 1'b0;
              state_q       <= S_PAUSE;
            end
          end else if (timer_q == TO_LAST) begin
            player_turn_q <= 1'b0;
            game_over_q   <= 1'b1;
            state_q       <= S_LOSE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.show_on     = show_on_q;
  assign bus.show_key    = show_key_q;
  assign bus.player_turn = player_turn_q;
  assign bus.level       = level_q;
  assign bus.game_over   = game_over_q;
  assign bus.win         = win_q;

endmodule

// File: doc/simon_engine.md
Name: simon_engine

Overview:
- Parametrised memory-sequence game engine, successor to the fixed 4-key, 15-level Simon core.
- Generates a growing pseudo-random key sequence, plays it back with programmable on/off timing, then checks player presses with a timeout.
- Sits between the debounced keypad/input block and the LED/tone/display drivers.
- Adds what the fixed core lacked: N keys, configurable depth, an explicit start/restart handshake, a win indication, and an internal LFSR.

Parameters:
- NUM_KEYS, 4, number of distinct keys; must be 2..16.
- MAX_LEVEL, 16, sequence length that wins the game; must be 1..64.
- SHOW_TICKS, 30, clock cycles each key is displayed.
- GAP_TICKS, 30, dark cycles between displayed keys and before each replay.
- TIMEOUT_TICKS, 120, cycles allowed between player presses.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk  in  1  game tick clock (60 Hz in system).
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle pulse; begins a game from IDLE, WIN or LOSE.
- player_valid  in  1  single-cycle press strobe.
- player_key  in  KEY_W  pressed key index, where KEY_W = max(1, clog2(NUM_KEYS)).
- show_on  out  1  a key is being displayed.
- show_key  out  KEY_W  key being displayed (valid when show_on=1).
- player_turn  out  1  engine is waiting for player input.
- level  out  LVL_W  current sequence length, where LVL_W = clog2(MAX_LEVEL+1).
- game_over  out  1  game ended (lose or win); sticky.
- win  out  1  game ended by completing MAX_LEVEL; sticky.

Behaviour:
- Reset: state=IDLE; all outputs 0; idx=0; timers=0; LFSR=LFSR_SEED. Sequence memory is not cleared.
- Reset asserted mid-game aborts immediately to these values.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Free-running every cycle after reset.
  - New key = LFSR[KEY_W-1:0]; if the value is >= NUM_KEYS, subtract NUM_KEYS.
- Sequence memory: MAX_LEVEL entries x KEY_W bits.
- IDLE / WIN / LOSE:
  - start=1 → mem[0] <= new key, level <= 1, idx <= 0, game_over <= 0, win <= 0, go to PAUSE.
  - start is ignored in every other state.
- PAUSE:
  - All display outputs 0 for GAP_TICKS cycles.
  - Then go to SHOW_ON with idx=0.
- SHOW_ON:
  - show_on=1, show_key=mem[idx] for exactly SHOW_TICKS cycles.
  - Then go to SHOW_OFF.
- SHOW_OFF:
  - show_on=0 for GAP_TICKS cycles.
  - If idx==level-1: idx <= 0, timer <= 0, go to WAIT_KEY.
  - Else: idx++, go to SHOW_ON.
- WAIT_KEY (player_turn=1):
  - player_valid with player_key != mem[idx] → LOSE.
  - player_valid with a match and idx < level-1 → idx++, timer <= 0.
  - player_valid with a match and idx == level-1:
    - If level == MAX_LEVEL → WIN.
    - Else mem[level] <= new key, level++, idx <= 0, go to PAUSE.
  - No valid → timer++; when timer == TIMEOUT_TICKS-1 → LOSE.
  - player_valid takes precedence over a timeout in the same cycle.
  - player_key values >= NUM_KEYS are always mismatches.
- LOSE: game_over=1, win=0. WIN: game_over=1, win=1. level holds its final value in both.
- Latency: all outputs are registered and change the cycle after the triggering edge.
- player_valid outside WAIT_KEY is ignored.

Optional Feature:
- Macro SIMON_SPEEDUP_EN.
- Defined: effective show time = max(SHOW_TICKS - 2*(level-1), SHOW_TICKS/4). GAP_TICKS and TIMEOUT_TICKS are unchanged.
- Undefined: show time is always SHOW_TICKS; the speedup logic is not synthesised.

Test Plan:
All scenarios use NUM_KEYS=4, MAX_LEVEL=4, SHOW_TICKS=3, GAP_TICKS=2, TIMEOUT_TICKS=10, no macro unless stated.
- Reset, then start pulse → all outputs 0 during reset; after start: level=1; 2 dark cycles; show_on=1 for 3 cycles; 2 dark cycles; player_turn=1.
- Correct press of the shown key at level 1 → level=2; replay shows 2 keys, the first equal to the level-1 key; each key is on 3 cycles with 2-cycle gaps.
- Wrong key in WAIT_KEY → next cycle game_over=1, win=0, player_turn=0, level unchanged; start pulse restarts with level=1.
- No press in WAIT_KEY → game_over=1 exactly 10 cycles after player_turn rises; a press landing on the 10th cycle is still evaluated as a press.
- Correct replay through all 4 levels → win=1 and game_over=1 after the 4th key of level 4; further player_valid pulses have no effect.
- Reset asserted during SHOW_ON at level 3 → show_on, level and game_over are 0 immediately, without waiting for a clock edge; state=IDLE.
- With SIMON_SPEEDUP_EN and SHOW_TICKS=8 → show time is 8, 6, 4, 2 cycles for levels 1-4.
